// File: rtl/experiment_run_scheduler_if.sv
// Command/status and experiment-FSM handshake bundle for experiment_run_scheduler.
// master = host + experiment FSM side, slave = the scheduler itself.
interface experiment_run_scheduler_if #(
    parameter int W_SHOT     = 16,
    parameter int W_INTERVAL = 32
);
    logic                  cmd_run;
    logic                  cmd_abort;
    logic [W_SHOT-1:0]     shot_count;
    logic [W_INTERVAL-1:0] interval;
    logic [3:0]            max_retries;
    logic                  fsm_busy;
    logic                  fsm_done;
    logic                  fsm_error;
    logic                  exp_start;
    logic                  running;
    logic [W_SHOT-1:0]     shots_ok;
    logic [W_SHOT-1:0]     shots_failed;
    logic                  run_done;
    logic                  fault;
    logic                  aborted;

    modport master (
        output cmd_run, cmd_abort, shot_count, interval, max_retries,
               fsm_busy, fsm_done, fsm_error,
        input  exp_start, running, shots_ok, shots_failed, run_done, fault, aborted
    );

    modport slave (
        input  cmd_run, cmd_abort, shot_count, interval, max_retries,
               fsm_busy, fsm_done, fsm_error,
        output exp_start, running, shots_ok, shots_failed, run_done, fault, aborted
    );
endinterface

// File: rtl/experiment_run_scheduler.sv
// Multi-shot run sequencer: issues one exp_start pulse per shot, retries failed
// shots within a budget, counts results and reports done / fault / abort.
module experiment_run_scheduler #(
    parameter int W_SHOT      = 16,
    parameter int W_INTERVAL  = 32,
    parameter int START_LEN   = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    experiment_run_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_SHOT,
        S_COOLDOWN,
        S_FINISH,
        S_FAULT
    } state_t;

    localparam logic [W_INTERVAL-1:0] START_LAST = W_INTERVAL'(START_LEN - 1);
    localparam logic [W_INTERVAL-1:0] ACK_LAST   = W_INTERVAL'(ACK_TIMEOUT);

    state_t                state_q, state_d;
    logic [W_INTERVAL-1:0] cnt_q, cnt_d;
    logic [W_SHOT-1:0]     shot_count_q, shot_count_d;
    logic [W_INTERVAL-1:0] interval_q, interval_d;
    logic [3:0]            max_retries_q, max_retries_d;
    logic [4:0]            retry_q, retry_d;
    logic [4:0]            retry_inc;
    logic [W_SHOT-1:0]     shots_ok_q, shots_ok_d;
    logic [W_SHOT-1:0]     shots_failed_q, shots_failed_d;
    logic                  exp_start_q, exp_start_d;
    logic                  running_q, running_d;
    logic                  run_done_q, run_done_d;
    logic                  fault_q, fault_d;
    logic                  aborted_q, aborted_d;
    logic                  in_run;

    // One extra retry bit so a budget of 15 can still be exceeded without wrapping.
    assign retry_inc = (retry_q == 5'h1F) ? retry_q : retry_q + 5'd1;
    assign in_run    = (state_q != S_IDLE) && (state_q != S_FAULT);

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        shot_count_d   = shot_count_q;
        interval_d     = interval_q;
        max_retries_d  = max_retries_q;
        retry_d        = retry_q;
        shots_ok_d     = shots_ok_q;
        shots_failed_d = shots_failed_q;
        exp_start_d    = 1'b0;
        run_done_d     = 1'b0;
        fault_d        = fault_q;
        aborted_d      = aborted_q;

        if (in_run && bus.cmd_abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE, S_FAULT: begin
                    if (bus.cmd_run && !bus.cmd_abort) begin
                        shot_count_d   = bus.shot_count;
                        interval_d     = bus.interval;
                        max_retries_d  = bus.max_retries;
                        retry_d        = '0;
                        shots_ok_d     = '0;
                        shots_failed_d = '0;
                        fault_d        = 1'b0;
                        aborted_d      = 1'b0;
                        if (bus.shot_count == '0) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d     = S_START;
                            exp_start_d = 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (cnt_q == START_LAST) begin
                        state_d = S_WAIT_ACK;
                    end else begin
                        exp_start_d = 1'b1;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // Busy on the final count still counts as an acknowledge.
                    if (bus.fsm_busy) begin
                        state_d = S_WAIT_SHOT;
                    end else if (cnt_q == ACK_LAST) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_SHOT: begin
                    if (bus.fsm_error) begin
                        if (shots_failed_q != '1) shots_failed_d = shots_failed_q + 1'b1;
                        retry_d = retry_inc;
                        if (retry_inc > {1'b0, max_retries_q}) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = S_COOLDOWN;
                        end
                    end else if (bus.fsm_done) begin
                        if (shots_ok_q != '1) shots_ok_d = shots_ok_q + 1'b1;
                        retry_d = '0;
                        state_d = S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (cnt_q >= interval_q) begin
                        if (shots_ok_q == shot_count_q) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d     = S_START;
                            exp_start_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    run_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        running_d = (state_d != S_IDLE) && (state_d != S_FAULT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            shot_count_q   <= '0;
            interval_q     <= '0;
            max_retries_q  <= '0;
            retry_q        <= '0;
            shots_ok_q     <= '0;
            shots_failed_q <= '0;
            exp_start_q    <= 1'b0;
            running_q      <= 1'b0;
            run_done_q     <= 1'b0;
            fault_q        <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shot_count_q   <= shot_count_d;
            interval_q     <= interval_d;
            max_retries_q  <= max_retries_d;
            retry_q        <= retry_d;
            shots_ok_q     <= shots_ok_d;
            shots_failed_q <= shots_failed_d;
            exp_start_q    <= exp_start_d;
            running_q      <= running_d;
            run_done_q     <= run_done_d;
            fault_q        <= fault_d;
            aborted_q      <= aborted_d;
        end
    end

    assign bus.exp_start    = exp_start_q;
    assign bus.running      = running_q;
    assign bus.shots_ok     = shots_ok_q;
    assign bus.shots_failed = shots_failed_q;
    assign bus.run_done     = run_done_q;
    assign bus.fault        = fault_q;
    assign bus.aborted      = aborted_q;
endmodule
